poly1305_feeder: RTL and testbench

POLY1305_FEEDER -- requirements
Module: poly1305_feeder

---
 rtl/poly1305_feeder_if.sv | 10 +
 rtl/poly1305_feeder.sv | 193 +++++++++++++++++++
 tb/tb_poly1305_feeder.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/poly1305_feeder_if.sv
// Byte-stream handshake that delivers message bytes into poly1305_feeder.
interface poly1305_feeder_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;

  modport master (output in_data, output in_valid, output in_last, input in_ready);
  modport slave  (input in_data, input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/poly1305_feeder.sv
// Packs a byte stream into 16-byte Poly1305 blocks, sequences the external core
// one block at a time and reports the final tag with an optional tag compare.
module poly1305_feeder #(
  parameter bit TAG_CHECK = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [255:0]       key,
  input  logic [127:0]       exp_tag,
  poly1305_feeder_if.slave   in_if,
  output logic               busy,
  output logic [127:0]       core_r,
  output logic [127:0]       core_s,
  output logic [127:0]       core_m,
  output logic               core_fb,
  output logic               core_ld,
  output logic               core_first,
  input  logic [127:0]       core_p,
  input  logic               core_rdy,
  output logic [127:0]       tag,
  output logic               tag_valid,
  output logic               tag_ok
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       count_q, count_d;
  logic             first_pending_q, first_pending_d;
  logic             last_blk_q, last_blk_d;
  logic [15:0][7:0] m_q, m_d;
  logic             fb_q, fb_d;
  logic             first_q, first_d;
  logic             ld_q, ld_d;
  logic [127:0]     r_q, r_d;
  logic [127:0]     s_q, s_d;
  logic [127:0]     exp_tag_q, exp_tag_d;
  logic [127:0]     tag_q, tag_d;
  logic             tag_valid_q, tag_valid_d;
  logic             tag_ok_q, tag_ok_d;
  logic             busy_q, busy_d;
  logic             in_ready_q, in_ready_d;
  logic             accept;

  // in_ready_q is only ever high in COLLECT, so it also qualifies the state.
  assign accept = in_if.in_valid & in_ready_q;

  always_comb begin
    // NOTE: every *_d starts as its held value so no path through the case
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_d         = state_q;
    count_d         = count_q;
    first_pending_d = first_pending_q;
    last_blk_d      = last_blk_q;
    m_d             = m_q;
    fb_d            = fb_q;
    first_d         = first_q;
    ld_d            = 1'b0;
    r_d             = r_q;
    s_d             = s_q;
    exp_tag_d       = exp_tag_q;
    tag_d           = tag_q;
    tag_valid_d     = 1'b0;
    tag_ok_d        = tag_ok_q;
    busy_d          = busy_q;
    in_ready_d      = in_ready_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          r_d             = key[127:0];
          s_d             = key[255:128];
          exp_tag_d       = exp_tag;
          first_pending_d = 1'b1;
          last_blk_d      = 1'b0;
          count_d         = 4'd0;
          m_d             = '0;
          busy_d          = 1'b1;
          in_ready_d      = 1'b1;
          state_d         = S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (accept) begin
          m_d[count_q] = in_if.in_data;
          count_d      = count_q + 4'd1;
          if (count_q == 4'd15 || in_if.in_last) begin
            // A short final block gets the 0x01 pad byte right after its data.
            if (count_q != 4'd15) begin
              m_d[count_q + 4'd1] = 8'h01;
            end
            fb_d            = (count_q == 4'd15);
            first_d         = first_pending_q;
            first_pending_d = 1'b0;
            last_blk_d      = in_if.in_last;
            ld_d            = 1'b1;
            in_ready_d      = 1'b0;
            state_d         = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (core_rdy) begin
          if (last_blk_q) begin
            tag_d       = core_p;
            tag_ok_d    = TAG_CHECK ? (core_p == exp_tag_q) : 1'b0;
            tag_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            m_d        = '0;
            count_d    = 4'd0;
            in_ready_d = 1'b1;
            state_d    = S_COLLECT;
          end
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: the block buffer is reset along with the control state because it
    // drives core_m directly and must read zero after reset.
    if (reset) begin
      state_q         <= S_IDLE;
      count_q         <= 4'd0;
      first_pending_q <= 1'b0;
      last_blk_q      <= 1'b0;
      m_q             <= '0;
      fb_q            <= 1'b0;
      first_q         <= 1'b0;
      ld_q            <= 1'b0;
      r_q             <= '0;
      s_q             <= '0;
      exp_tag_q       <= '0;
      tag_q           <= '0;
      tag_valid_q     <= 1'b0;
      tag_ok_q        <= 1'b0;
      busy_q          <= 1'b0;
      in_ready_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q         <= state_d;
      count_q         <= count_d;
      first_pending_q <= first_pending_d;
      last_blk_q      <= last_blk_d;
      m_q             <= m_d;
      fb_q            <= fb_d;
      first_q         <= first_d;
      ld_q            <= ld_d;
      r_q             <= r_d;
      s_q             <= s_d;
      exp_tag_q       <= exp_tag_d;
      tag_q           <= tag_d;
      tag_valid_q     <= tag_valid_d;
      tag_ok_q        <= tag_ok_d;
      busy_q          <= busy_d;
      in_ready_q      <= in_ready_d;
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign busy           = busy_q;
  assign core_r         = r_q;
  assign core_s         = s_q;
  assign core_m         = m_q;
  assign core_fb        = fb_q;
  assign core_ld        = ld_q;
  assign core_first     = first_q;
  assign tag            = tag_q;
  assign tag_valid      = tag_valid_q;
  assign tag_ok         = tag_ok_q;

endmodule

// File: tb/tb_poly1305_feeder.sv
// Scoreboard bench for poly1305_feeder: a behavioural Poly1305 core answers each
// block load, a monitor checks every load and tag against queued expectations.
module tb_poly1305_feeder;

  localparam logic [255:0] RFC_KEY =
    256'h1bf54941aff6bf4afdb20dfb8a800301_a806d542fe52447f336d555778bed685;
  localparam logic [127:0] RFC_TAG = 128'ha927010caf8b2bc2c6365130c11d06a8;
  localparam logic [127:0] RFC_B1  = 128'h6f4620636968706172676f7470797243;
  localparam logic [127:0] RFC_B2  = 128'h6f7247206863726165736552206d7572;
  localparam logic [127:0] RFC_B3  = 128'h00000000000000000000000000017075;
  localparam logic [131:0] P1305   = (132'd1 << 130) - 132'd5;
  localparam string        RFC_MSG = "Cryptographic Forum Research Group";

  typedef struct packed {
    logic         first;
    logic         fb;
    logic [127:0] m;
  } blk_t;

  typedef struct packed {
    logic [127:0] tag;
    logic         ok;
  } tag_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [255:0] key;
  logic [127:0] exp_tag;
  logic         busy;
  logic [127:0] core_r, core_s, core_m, core_p, tag;
  logic         core_fb, core_ld, core_first, core_rdy, tag_valid, tag_ok;

  poly1305_feeder_if in_if ();

  poly1305_feeder #(.TAG_CHECK(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .key        (key),
    .exp_tag    (exp_tag),
    .in_if      (in_if),
    .busy       (busy),
    .core_r     (core_r),
    .core_s     (core_s),
    .core_m     (core_m),
    .core_fb    (core_fb),
    .core_ld    (core_ld),
    .core_first (core_first),
    .core_p     (core_p),
    .core_rdy   (core_rdy),
    .tag        (tag),
    .tag_valid  (tag_valid),
    .tag_ok     (tag_ok)
  );

  always #5 clk = ~clk;

  int           n_total = 0;
  int           n_bad   = 0;
  blk_t         blk_q[$];
  tag_t         tag_q[$];
  logic [7:0]   msg_q[$];
  logic [255:0] cur_key = '0;
  int           core_delay = 1;
  bit           waiting = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_total++;
    n_bad++;
    $display("FAIL %s: event did not match expectation", name);
  endtask

  // One Poly1305 block step: acc = ((acc + m + fb*2^128) * clamp(r)) mod 2^130-5.
  function automatic logic [129:0] blk_step(input logic [129:0] acc, input logic [127:0] m,
                                            input logic fb, input logic [127:0] r_raw);
    logic [127:0] r;
    logic [130:0] sum;
    logic [261:0] prod;
    logic [131:0] x;
    r    = r_raw & 128'h0ffffffc0ffffffc0ffffffc0fffffff;
    sum  = {1'b0, acc} + {3'b000, m} + (fb ? {3'b001, 128'h0} : 131'h0);
    prod = {131'h0, sum} * {134'h0, r};
    x    = {2'b00, prod[129:0]} + prod[261:130] * 132'd5;
    x    = {2'b00, x[129:0]} + {130'h0, x[131:130]} * 132'd5;
    if (x >= P1305) x = x - P1305;
    return x[129:0];
  endfunction

  function automatic logic [127:0] poly_ref(input logic [255:0] k, input int n);
    logic [129:0] acc;
    logic [127:0] m;
    int           len;
    acc = '0;
    for (int b = 0; b < n; b += 16) begin
      m   = '0;
      len = (n - b < 16) ? n - b : 16;
      for (int j = 0; j < len; j++) m[8*j +: 8] = msg_q[b+j];
      if (len < 16) m[8*len +: 8] = 8'h01;
      acc = blk_step(acc, m, len == 16, k[127:0]);
    end
    return acc[127:0] + k[255:128];
  endfunction

  // Behavioural core: answers each load after core_delay cycles; a result in
  // flight survives a feeder reset on purpose.
  initial begin : core_model
    logic [129:0] cm_acc;
    logic [127:0] cm_res;
    int           cm_cnt;
    cm_acc = '0; cm_res = '0; cm_cnt = 0;
    core_rdy = 1'b0; core_p = '0;
    forever begin
      @(posedge clk); #1;
      core_rdy = 1'b0;
      if (cm_cnt > 0) begin
        cm_cnt--;
        if (cm_cnt == 0) begin
          core_rdy = 1'b1;
          core_p   = cm_res;
        end
      end
      if (core_ld) begin
        cm_acc = blk_step(core_first ? 130'h0 : cm_acc, core_m, core_fb, core_r);
        cm_res = cm_acc[127:0] + core_s;
        cm_cnt = core_delay;
      end
    end
  end

  initial begin : monitor
    blk_t eb;
    blk_t cur_blk;
    tag_t et;
    bit   prev_tv;
    prev_tv = 1'b0;
    cur_blk = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_tv = 1'b0;
      end else begin
        if (core_ld) begin
          if (blk_q.size() == 0) begin
            fail_now("unexpected_core_ld");
          end else begin
            eb = blk_q.pop_front();
            check("ld_first", 128'(core_first), 128'(eb.first));
            check("ld_fb", 128'(core_fb), 128'(eb.fb));
            check("ld_m", core_m, eb.m);
            check("ld_r", core_r, cur_key[127:0]);
            check("ld_s", core_s, cur_key[255:128]);
            cur_blk = eb;
          end
          waiting = 1'b1;
        end else if (waiting) begin
          check("ready_low_in_wait", 128'(in_if.in_ready), 128'd0);
          check("hold_m", core_m, cur_blk.m);
          check("hold_ctl", 128'({core_first, core_fb}), 128'({cur_blk.first, cur_blk.fb}));
          if (core_rdy) waiting = 1'b0;
        end
        if (tag_valid) begin
          check("tag_valid_single", 128'(prev_tv), 128'd0);
          check("busy_with_tag_valid", 128'(busy), 128'd1);
          if (tag_q.size() == 0) begin
            fail_now("unexpected_tag_valid");
          end else begin
            et = tag_q.pop_front();
            check("tag", tag, et.tag);
            check("tag_ok", 128'(tag_ok), 128'(et.ok));
          end
        end
        prev_tv = tag_valid;
      end
    end
  end

  task automatic load_msg(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(RFC_MSG[i]);
  endtask

  task automatic check_reset_vals(input string sfx);
    check({"rst_busy_", sfx}, 128'(busy), 128'd0);
    check({"rst_in_ready_", sfx}, 128'(in_if.in_ready), 128'd0);
    check({"rst_core_ld_", sfx}, 128'(core_ld), 128'd0);
    check({"rst_core_fb_", sfx}, 128'(core_fb), 128'd0);
    check({"rst_core_first_", sfx}, 128'(core_first), 128'd0);
    check({"rst_core_m_", sfx}, core_m, 128'd0);
    check({"rst_core_r_", sfx}, core_r, 128'd0);
    check({"rst_core_s_", sfx}, core_s, 128'd0);
    check({"rst_tag_", sfx}, tag, 128'd0);
    check({"rst_tag_valid_", sfx}, 128'(tag_valid), 128'd0);
    check({"rst_tag_ok_", sfx}, 128'(tag_ok), 128'd0);
  endtask

  task automatic send_bytes(input int n_send, input bit gap, input bit poke);
    int idx    = 0;
    int budget = 0;
    bit phase  = 1'b0;
    bit poked  = 1'b0;
    while (idx < n_send && budget < 3000) begin
      @(negedge clk);
      budget++;
      start = 1'b0;
      key   = cur_key;
      if (poke && !poked && waiting && !core_ld) begin
        start   = 1'b1;
        key     = ~cur_key;
        exp_tag = ~exp_tag;
        poked   = 1'b1;
      end
      phase = ~phase;
      if (gap && !phase) begin
        in_if.in_valid = 1'b0;
      end else begin
        in_if.in_valid = 1'b1;
        in_if.in_data  = msg_q[idx];
        in_if.in_last  = (idx == msg_q.size() - 1);
        if (in_if.in_ready) idx++;
      end
    end
    @(negedge clk);
    start          = 1'b0;
    key            = cur_key;
    in_if.in_valid = 1'b0;
    in_if.in_last  = 1'b0;
    if (idx < n_send) fail_now("send_timeout");
    if (poke && !poked) fail_now("start_poke_not_issued");
  endtask

  task automatic run_msg(input logic [255:0] k, input logic [127:0] et, input int n_send,
                         input bit gap, input bit poke);
    @(negedge clk);
    start   = 1'b1;
    key     = k;
    exp_tag = et;
    cur_key = k;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 128'(busy), 128'd1);
    check("in_ready_after_start", 128'(in_if.in_ready), 128'd1);
    send_bytes(n_send, gap, poke);
  endtask

  task automatic wait_tag(input logic [127:0] et, input logic ok);
    int cyc = 0;
    while (!tag_valid && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    if (!tag_valid) begin
      fail_now("tag_valid_timeout");
    end else begin
      @(negedge clk);
      check("tag_valid_drop", 128'(tag_valid), 128'd0);
      check("busy_drop", 128'(busy), 128'd0);
      check("tag_hold", tag, et);
      check("tag_ok_hold", 128'(tag_ok), 128'(ok));
    end
  endtask

  task automatic push_rfc_blocks();
    blk_q.push_back('{first: 1'b1, fb: 1'b1, m: RFC_B1});
    blk_q.push_back('{first: 1'b0, fb: 1'b1, m: RFC_B2});
    blk_q.push_back('{first: 1'b0, fb: 1'b0, m: RFC_B3});
  endtask

  initial begin : stimulus
    logic [127:0] ref_tag;
    bit           stray;
    reset = 1'b1; start = 1'b0; key = '0; exp_tag = '0;
    in_if.in_valid = 1'b0; in_if.in_data = 8'h00; in_if.in_last = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("init");
    reset = 1'b0;

    // RFC 7539 2.5.2 vector, fast core.
    core_delay = 1;
    load_msg(34);
    push_rfc_blocks();
    tag_q.push_back('{tag: RFC_TAG, ok: 1'b1});
    run_msg(RFC_KEY, RFC_TAG, 34, 1'b0, 1'b0);
    wait_tag(RFC_TAG, 1'b1);

    // Exactly one full block with in_last on byte 15: no pad block.
    load_msg(16);
    ref_tag = poly_ref(RFC_KEY, 16);
    blk_q.push_back('{first: 1'b1, fb: 1'b1, m: RFC_B1});
    tag_q.push_back('{tag: ref_tag, ok: 1'b1});
    run_msg(RFC_KEY, ref_tag, 16, 1'b0, 1'b0);
    wait_tag(ref_tag, 1'b1);

    // Wrong expected tag: same tag, tag_ok low.
    load_msg(34);
    push_rfc_blocks();
    tag_q.push_back('{tag: RFC_TAG, ok: 1'b0});
    run_msg(RFC_KEY, RFC_TAG ^ 128'd1, 34, 1'b0, 1'b0);
    wait_tag(RFC_TAG, 1'b0);

    // Gapped input, slow core, start pulsed with a different key during WAIT.
    core_delay = 20;
    push_rfc_blocks();
    tag_q.push_back('{tag: RFC_TAG, ok: 1'b1});
    run_msg(RFC_KEY, RFC_TAG, 34, 1'b1, 1'b1);
    wait_tag(RFC_TAG, 1'b1);

    // Reset while waiting on block 2; the late core result must be ignored.
    blk_q.push_back('{first: 1'b1, fb: 1'b1, m: RFC_B1});
    blk_q.push_back('{first: 1'b0, fb: 1'b1, m: RFC_B2});
    run_msg(RFC_KEY, RFC_TAG, 32, 1'b0, 1'b0);
    @(negedge clk);
    check("in_wait_before_reset", 128'(waiting), 128'd1);
    reset = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    waiting = 1'b0;
    check_reset_vals("mid_wait");
    blk_q.delete();
    tag_q.delete();
    stray = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (tag_valid || busy || core_ld) stray = 1'b1;
    end
    check("idle_after_reset", 128'(stray), 128'd0);
    core_delay = 1;
    push_rfc_blocks();
    tag_q.push_back('{tag: RFC_TAG, ok: 1'b1});
    run_msg(RFC_KEY, RFC_TAG, 34, 1'b0, 1'b0);
    wait_tag(RFC_TAG, 1'b1);

    // Single zero byte: one partial block 0x0100.
    msg_q.delete();
    msg_q.push_back(8'h00);
    ref_tag = poly_ref(RFC_KEY, 1);
    blk_q.push_back('{first: 1'b1, fb: 1'b0, m: 128'h0100});
    tag_q.push_back('{tag: ref_tag, ok: 1'b1});
    run_msg(RFC_KEY, ref_tag, 1, 1'b0, 1'b0);
    wait_tag(ref_tag, 1'b1);

    repeat (3) @(negedge clk);
    check("blk_q_drained", 128'(blk_q.size()), 128'd0);
    check("tag_q_drained", 128'(tag_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
